btb_predictor: RTL
==================

# btb_predictor

Parametrised branch target buffer (BTB) for the pipeline's fetch stage, replacing the fixed 4-entry most-recent-target predictor. It holds up to `ENTRIES` fully associative {branch PC, target, 2-bit saturating counter} records with true-LRU replacement. It supplies a same-cycle next-PC prediction plus a registered copy for mispredict checking in a later stage. It is trained by the execute stage on every resolved branch.

## Interface
Parameters:
- `PC_W`, 32, PC and target width in bits.
- `ENTRIES`, 4, number of BTB entries; power of two, 2..32.
- `INSTR_BYTES`, 4, sequential PC increment.

Ports:
- `clk`  in  1  Single clock; all state updates on the rising edge.
- `rst_n`  in  1  Reset, asynchronous, active-low.
- `pc`  in  PC_W  Fetch PC to predict.
- `upd_valid`  in  1  Resolved-branch update strobe.
- `upd_pc`  in  PC_W  PC of the resolved branch.
- `upd_target`  in  PC_W  Resolved target.
- `upd_taken`  in  1  Branch outcome.
- `flush`  in  1  Synchronous invalidate of all entries.
- `pred_pc`  out  PC_W  Combinational predicted next PC.
- `pred_hit`  out  1  Combinational: `pc` matched a valid entry.
- `pred_pc_q`  out  PC_W  `pred_pc` registered.
- `pred_taken_q`  out  1  Registered: prediction was a target, not `pc + INSTR_BYTES`.
- `occupancy`  out  clog2(ENTRIES)+1  Number of valid entries.

## Operation
- Entry fields: `valid`, `tag` (full PC_W), `target`, `ctr[1:0]`, `age[clog2(ENTRIES)-1:0]`. Age 0 is MRU. Valid entries hold distinct ages.
- Lookup: a hit on a valid entry with `ctr >= 2` sets `pred_pc = target`. Otherwise `pred_pc = pc + INSTR_BYTES`, which wraps modulo 2^PC_W. At most one entry can match.
- Update hit, `upd_valid=1` and `upd_pc` matches:
  - `ctr` increments on taken and decrements on not-taken, saturating at 3 and 0.
  - `target` is overwritten with `upd_target` only when taken.
  - The entry becomes MRU. Valid entries younger than its old age age by one.
- Update miss with `upd_taken=1`: allocate.
  - Victim is the lowest-index invalid entry, or else the entry with age `ENTRIES-1`.
  - New entry: `{valid=1, tag=upd_pc, target=upd_target, ctr=2'b10}`, age 0. All other valid entries younger than the victim's old age age by one.
  - `occupancy` increments only if the victim was invalid.
- Update miss with `upd_taken=0`: no state change.
- `flush=1`: all `valid` and `occupancy` clear on the next edge. Flush overrides a same-cycle update.

## Timing
- On `rst_n` low, immediately and asynchronously:
  - All `valid=0`, `ctr=0`, `age=0`.
  - `occupancy=0`, `pred_pc_q=0`, `pred_taken_q=0`.
- While the table is empty after reset, `pred_pc = pc + INSTR_BYTES` and `pred_hit = 0`.
- Lookup latency 0 cycles. `pred_pc_q` and `pred_taken_q` carry the value from 1 cycle earlier.
- An update at edge N is visible to lookup from cycle N+1. A same-cycle lookup of `upd_pc` sees pre-update state.
- Reset asserted mid-operation discards all entries. Reset deassertion is used synchronously to `clk`.

## Configuration
- `BTB_SAT_COUNTER_EN` defined: 2-bit counter behaviour as above.
- Undefined:
  - No `ctr` storage; any hit predicts `target`.
  - A not-taken update that hits invalidates that entry, decrements `occupancy`, and leaves other ages unchanged; the freed slot is reused first.
  - Taken hit or miss behaves as above.

## Structure
- Package `btb_pkg`: counter encodings `CTR_SNT=2'b00`, `CTR_WNT=2'b01`, `CTR_WT=2'b10`, `CTR_ST=2'b11`, the saturating-increment/decrement function, and the default `INSTR_BYTES`.
- Sub-module `btb_lru_ages`: holds the age vector and produces the victim index. Inputs are touch index, touch strobe, invalidate strobe and valid vector.

## Test plan
- Reset then `pc=0x100` -> `pred_pc=0x104`, `pred_hit=0`, `occupancy=0`.
- Update `0x100`->`0x200` taken; next cycle `pc=0x100` -> `pred_pc=0x200`, `pred_hit=1`; following cycle `pred_pc_q=0x200`, `pred_taken_q=1`.
- Two not-taken updates on `0x100` -> ctr goes 2→1→0 and `pred_pc=0x104` with `pred_hit=1`. Without the macro, the first not-taken update instead gives `pred_hit=0` and `occupancy=0`.
- Fill with taken updates from `0x10`, `0x20`, `0x30`, `0x40` (ENTRIES=4), touch `0x10`, then insert `0x50` -> `0x20` is evicted and `occupancy` stays 4.
- Same-cycle `flush=1` and taken update `0x60` -> next cycle `occupancy=0` and `pc=0x60` gives `0x64`.
- `pc=0xFFFFFFFC` with empty table -> `pred_pc=0x00000000`. Assert `rst_n` mid-stream -> outputs zero without a clock edge.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared definitions for the branch target buffer: counter encodings,
// saturating counter helpers and the default sequential PC increment.
package btb_pkg;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  localparam int BTB_INSTR_BYTES = 4;

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == CTR_ST) ? CTR_ST : c + 2'd1;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
  endfunction

endpackage

// File: rtl/btb_lru_ages.sv
// True-LRU age vector for the BTB (age 0 = MRU) and victim selection:
// lowest-index invalid entry first, otherwise the entry holding the oldest age.
module btb_lru_ages import btb_pkg::*; #(
  parameter int ENTRIES = 4,
  localparam int IW = $clog2(ENTRIES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IW-1:0]      touch_idx,
  input  logic               touch,
  input  logic               inval,
  input  logic [ENTRIES-1:0] valid,
  output logic [IW-1:0]      victim
);

  logic [ENTRIES-1:0][IW-1:0] r_age;
  logic [ENTRIES-1:0]         w_used;
  logic [IW-1:0]              w_free_age;
  logic [IW-1:0]              w_old_age;
  logic                       w_found;

  // An invalid slot has no meaningful age; it takes the lowest age not held by
  // any valid entry, so only valid entries below that gap shift and ages stay distinct.
  always_comb begin
    w_used     = '0;
    w_free_age = '0;
    w_found    = 1'b0;
    victim     = '0;
    for (int i = 0; i < ENTRIES; i++)
      if (valid[i]) w_used[r_age[i]] = 1'b1;
    for (int a = ENTRIES - 1; a >= 0; a--)
      if (!w_used[a]) w_free_age = IW'(a);
    w_old_age = valid[touch_idx] ? r_age[touch_idx] : w_free_age;
    for (int i = 0; i < ENTRIES; i++)
      if (!w_found && !valid[i]) begin
        victim  = IW'(i);
        w_found = 1'b1;
      end
    if (!w_found)
      for (int i = 0; i < ENTRIES; i++)
        if (r_age[i] == IW'(ENTRIES - 1)) victim = IW'(i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_age <= '0;
    end else if (inval) begin
      r_age <= '0;
    end else if (touch) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (IW'(i) == touch_idx)
          r_age[i] <= '0;
        else if (valid[i] && (r_age[i] < w_old_age))
          r_age[i] <= r_age[i] + 1'b1;
      end
    end
  end

endmodule

// File: rtl/btb_predictor.sv
// Fully associative BTB with true-LRU replacement and registered prediction copy.
// Define BTB_SAT_COUNTER_EN for 2-bit saturating direction counters per entry.
module btb_predictor import btb_pkg::*; #(
  parameter int PC_W        = 32,
  parameter int ENTRIES     = 4,
  parameter int INSTR_BYTES = BTB_INSTR_BYTES
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [PC_W-1:0]           pc,
  input  logic                      upd_valid,
  input  logic [PC_W-1:0]           upd_pc,
  input  logic [PC_W-1:0]           upd_target,
  input  logic                      upd_taken,
  input  logic                      flush,
  output logic [PC_W-1:0]           pred_pc,
  output logic                      pred_hit,
  output logic [PC_W-1:0]           pred_pc_q,
  output logic                      pred_taken_q,
  output logic [$clog2(ENTRIES):0]  occupancy
);

  localparam int IW = $clog2(ENTRIES);
  localparam int OW = IW + 1;
  localparam logic [PC_W-1:0] INC = PC_W'(INSTR_BYTES);

  logic [ENTRIES-1:0] r_valid;
  logic [PC_W-1:0]    r_tag    [ENTRIES];
  logic [PC_W-1:0]    r_target [ENTRIES];
`ifdef BTB_SAT_COUNTER_EN
  logic [1:0]         r_ctr    [ENTRIES];
`endif
  logic [PC_W-1:0]    r_pred_pc_q;
  logic               r_pred_taken_q;

  logic               w_hit, w_upd_hit, w_pred_taken, w_touch;
  logic [IW-1:0]      w_hit_idx, w_upd_idx, w_victim, w_touch_idx;

  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    w_upd_hit = 1'b0;
    w_upd_idx = '0;
    occupancy = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (r_valid[i] && (r_tag[i] == pc)) begin
        w_hit     = 1'b1;
        w_hit_idx = IW'(i);
      end
      if (r_valid[i] && (r_tag[i] == upd_pc)) begin
        w_upd_hit = 1'b1;
        w_upd_idx = IW'(i);
      end
      occupancy = occupancy + OW'(r_valid[i]);
    end
`ifdef BTB_SAT_COUNTER_EN
    w_pred_taken = w_hit && r_ctr[w_hit_idx][1];
    w_touch      = upd_valid && !flush && (w_upd_hit || upd_taken);
`else
    w_pred_taken = w_hit;
    w_touch      = upd_valid && !flush && upd_taken;
`endif
    w_touch_idx = w_upd_hit ? w_upd_idx : w_victim;
    pred_hit    = w_hit;
    pred_pc     = w_pred_taken ? r_target[w_hit_idx] : pc + INC;
  end

  btb_lru_ages #(.ENTRIES(ENTRIES)) u_ages (
    .clk       (clk),
    .rst_n     (rst_n),
    .touch_idx (w_touch_idx),
    .touch     (w_touch),
    .inval     (flush),
    .valid     (r_valid),
    .victim    (w_victim)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
`ifdef BTB_SAT_COUNTER_EN
        r_ctr[i]    <= CTR_SNT;
`endif
      end
    end else if (flush) begin
      r_valid <= '0;
    end else if (upd_valid) begin
      if (w_upd_hit) begin
        if (upd_taken) r_target[w_upd_idx] <= upd_target;
`ifdef BTB_SAT_COUNTER_EN
        r_ctr[w_upd_idx] <= upd_taken ? ctr_inc(r_ctr[w_upd_idx]) : ctr_dec(r_ctr[w_upd_idx]);
`else
        if (!upd_taken) r_valid[w_upd_idx] <= 1'b0;
`endif
      end else if (upd_taken) begin
        r_valid[w_victim]  <= 1'b1;
        r_tag[w_victim]    <= upd_pc;
        r_target[w_victim] <= upd_target;
`ifdef BTB_SAT_COUNTER_EN
        r_ctr[w_victim]    <= CTR_WT;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pred_pc_q    <= '0;
      r_pred_taken_q <= 1'b0;
    end else begin
      r_pred_pc_q    <= pred_pc;
      r_pred_taken_q <= w_pred_taken;
    end
  end

  assign pred_pc_q    = r_pred_pc_q;
  assign pred_taken_q = r_pred_taken_q;

endmodule
